// File: rtl/count_game_ctrl_if.sv
// Counter-digit bus between count_game_ctrl (master) and its cascade of
// up/down counter digits (slave).
interface count_game_ctrl_if #(
    parameter int unsigned DIGITS = 2
);
    logic              ctr_ld;
    logic [DIGITS-1:0] ctr_cnt;
    logic              ctr_up;
    logic [DIGITS-1:0] ctr_tc;

    modport master (output ctr_ld, ctr_cnt, ctr_up, input ctr_tc);
    modport slave  (input ctr_ld, ctr_cnt, ctr_up, output ctr_tc);
endinterface

// File: rtl/count_game_ctrl.sv
// Round controller for the counting game: sequences a cascade of 4-bit counter digits.
// Optional tap debounce is enabled by defining CNT_GAME_DEBOUNCE_EN.
module count_game_ctrl #(
    parameter int unsigned DIGITS     = 2,
    parameter logic [15:0] TIME_LIMIT = 16'd1000,
    parameter int unsigned DEB_CYCLES = 8
) (
    input  logic              inter_clk,
    input  logic              clr,
    input  logic              start,
    input  logic              dir,
    input  logic              tap,
    input  logic              tick,
    count_game_ctrl_if.master ctr,
    output logic [15:0]       timer,
    output logic [2:0]        state,
    output logic              win,
    output logic              lose
);

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("count_game_ctrl: DIGITS must be in 1..4");
    end
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
        $error("count_game_ctrl: DEB_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StArm  = 3'd2,
        StRun  = 3'd3,
        StWin  = 3'd4,
        StLose = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        up_q, up_d;
    logic        tap_s1_q, tap_s2_q, tap_edge_q;
    logic        count_en_q, count_en_d;
    logic        tap_clean;
    logic        all_tc;

    assign all_tc = &ctr.ctr_tc;

`ifdef CNT_GAME_DEBOUNCE_EN
    logic [7:0] deb_cnt_q;
    logic       deb_q;

    // deb_q follows the synchronized tap only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge inter_clk or negedge clr) begin
        if (!clr) begin
            deb_cnt_q <= 8'd0;
            deb_q     <= 1'b0;
        end else if (tap_s2_q == deb_q) begin
            deb_cnt_q <= 8'd0;
        end else if (deb_cnt_q == 8'(DEB_CYCLES - 1)) begin
            deb_cnt_q <= 8'd0;
            deb_q     <= tap_s2_q;
        end else begin
            deb_cnt_q <= deb_cnt_q + 8'd1;
        end
    end

    assign tap_clean = deb_q;
`else
    assign tap_clean = tap_s2_q;
`endif

    always_ff @(posedge inter_clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge inter_clk or negedge clr) begin
        if (!clr) begin
            timer_q    <= 16'd0;
            up_q       <= 1'b1;
            tap_s1_q   <= 1'b0;
            tap_s2_q   <= 1'b0;
            tap_edge_q <= 1'b0;
            count_en_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            up_q       <= up_d;
            tap_s1_q   <= tap;
            tap_s2_q   <= tap_s1_q;
            tap_edge_q <= tap_clean;
            count_en_q <= count_en_d;
        end
    end

    // Win beats timeout beats abort; taps never enter the state decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: state_d = StArm;
            StArm:  state_d = StRun;
            StRun: begin
                if (all_tc) begin
                    state_d = StWin;
                end else if (tick && (timer_q == 16'd0)) begin
                    state_d = StLose;
                end else if (start) begin
                    state_d = StLoad;
                end
            end
            StWin, StLose: if (start) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        timer_d    = timer_q;
        up_d       = up_q;
        count_en_d = tap_clean & ~tap_edge_q & (state_q == StRun) & ~all_tc;
        if (state_q == StLoad) begin
            timer_d = TIME_LIMIT;
            up_d    = dir;
        end else if ((state_q == StRun) && tick && (timer_q != 16'd0)) begin
            timer_d = timer_q - 16'd1;
        end
    end

    always_comb begin
        logic carry;
        carry       = count_en_q;
        ctr.ctr_ld  = (state_q == StLoad);
        ctr.ctr_up  = up_q;
        ctr.ctr_cnt = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            ctr.ctr_cnt[i] = carry & (state_q != StLoad);
            carry          = carry & ctr.ctr_tc[i];
        end
        timer = timer_q;
        state = state_q;
        win   = (state_q == StWin);
        lose  = (state_q == StLose);
    end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Directed bench for count_game_ctrl with a behavioural model of the counter digits.
module tb_count_game_ctrl;
    localparam int unsigned DIGITS     = 2;
    localparam logic [15:0] TIME_LIMIT = 16'd1000;
    localparam int unsigned DEB_CYCLES = 8;
`ifdef CNT_GAME_DEBOUNCE_EN
    localparam int EXP_LAT = 3 + DEB_CYCLES;
    localparam int HOLD    = 12;
    localparam int REL     = 14;
`else
    localparam int EXP_LAT = 3;
    localparam int HOLD    = 4;
    localparam int REL     = 4;
`endif

    logic        inter_clk = 1'b0;
    logic        clr       = 1'b1;
    logic        start     = 1'b0;
    logic        dir       = 1'b0;
    logic        tap       = 1'b0;
    logic        tick      = 1'b0;
    logic [15:0] timer;
    logic [2:0]  state;
    logic        win;
    logic        lose;

    int n_checks = 0;
    int n_fail   = 0;

    count_game_ctrl_if #(.DIGITS(DIGITS)) bus ();

    count_game_ctrl #(
        .DIGITS    (DIGITS),
        .TIME_LIMIT(TIME_LIMIT),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .inter_clk(inter_clk),
        .clr      (clr),
        .start    (start),
        .dir      (dir),
        .tap      (tap),
        .tick     (tick),
        .ctr      (bus),
        .timer    (timer),
        .state    (state),
        .win      (win),
        .lose     (lose)
    );

    always #5 inter_clk = ~inter_clk;

    // Counter digits: load 1, count up/down when enabled, terminal at F (up) or 0 (down).
    logic [3:0] dig [DIGITS] = '{default: 4'h0};

    always @(posedge inter_clk) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.ctr_ld) begin
                dig[i] <= 4'h1;
            end else if (bus.ctr_cnt[i]) begin
                dig[i] <= bus.ctr_up ? dig[i] + 4'h1 : dig[i] - 4'h1;
            end
        end
    end

    always_comb begin
        bus.ctr_tc = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            bus.ctr_tc[i] = bus.ctr_up ? (dig[i] == 4'hF) : (dig[i] == 4'h0);
        end
    end

    function automatic logic [7:0] digits();
        return {dig[1], dig[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge inter_clk);
            tick = 1'b0;
            @(negedge inter_clk);
        end
    endtask

    task automatic start_round(input logic d);
        dir   = d;
        start = 1'b1;
        @(negedge inter_clk);
        start = 1'b0;
    endtask

    // Hold tap for `hold` cycles, count cascade pulses and edges to the first count.
    task automatic tap_run(input int hold, output int p0, output int p1, output int lat);
        p0  = 0;
        p1  = 0;
        lat = 0;
        @(negedge inter_clk);
        tap = 1'b1;
        for (int i = 1; i <= hold + REL; i++) begin
            @(negedge inter_clk);
            if (bus.ctr_cnt[0]) begin
                p0++;
                if (lat == 0) lat = i;
            end
            if (bus.ctr_cnt[1]) p1++;
            if (i == hold) tap = 1'b0;
        end
    endtask

    task automatic wait_count(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge inter_clk);
            seen = bus.ctr_cnt[0];
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, lat, sum0, sum1, c1_tap;

        #2 clr = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_timer", 32'(timer), 32'd0);
        check("rst_ld", 32'(bus.ctr_ld), 32'd0);
        check("rst_cnt", 32'(bus.ctr_cnt), 32'd0);
        check("rst_up", 32'(bus.ctr_up), 32'd1);
        check("rst_win", 32'(win), 32'd0);
        check("rst_lose", 32'(lose), 32'd0);
        @(negedge inter_clk);
        clr = 1'b1;
        repeat (3) @(negedge inter_clk);
        check("idle_hold", 32'(state), 32'd0);
        tap_run(HOLD, p0, p1, lat);
        check("idle_tap", 32'(p0), 32'd0);

        // Down round: 0x11 -> 0x00 takes 17 taps
        start_round(1'b0);
        check("load_state", 32'(state), 32'd1);
        check("load_ld", 32'(bus.ctr_ld), 32'd1);
        check("load_cnt", 32'(bus.ctr_cnt), 32'd0);
        @(negedge inter_clk);
        check("arm_state", 32'(state), 32'd2);
        check("arm_ld", 32'(bus.ctr_ld), 32'd0);
        check("arm_up", 32'(bus.ctr_up), 32'd0);
        check("arm_timer", 32'(timer), 32'(TIME_LIMIT));
        check("arm_digits", 32'(digits()), 32'h11);
        @(negedge inter_clk);
        check("run_state", 32'(state), 32'd3);
`ifdef CNT_GAME_DEBOUNCE_EN
        tap_run(5, p0, p1, lat);
        check("glitch_pulses", 32'(p0), 32'd0);
        check("glitch_digits", 32'(digits()), 32'h11);
`endif
        tap_run(HOLD, p0, p1, lat);
        check("tap1_latency", 32'(lat), 32'(EXP_LAT));
        check("tap1_pulses", 32'(p0), 32'd1);
        check("tap1_digits", 32'(digits()), 32'h10);
        sum0   = 0;
        sum1   = 0;
        c1_tap = 0;
        for (int t = 2; t <= 17; t++) begin
            tap_run(HOLD, p0, p1, lat);
            sum0 += p0;
            sum1 += p1;
            if (p1 != 0) c1_tap = t;
        end
        check("down_pulses", 32'(sum0), 32'd16);
        check("carry_pulses", 32'(sum1), 32'd1);
        check("carry_tap", 32'(c1_tap), 32'd2);
        check("down_digits", 32'(digits()), 32'h00);
        check("down_state", 32'(state), 32'd4);
        check("down_win", 32'(win), 32'd1);
        check("down_lose", 32'(lose), 32'd0);
        tap_run(HOLD, p0, p1, lat);
        check("tap18_pulses", 32'(p0), 32'd0);
        check("tap18_digits", 32'(digits()), 32'h00);

        // Timeout round, counting up, no taps
        start_round(1'b1);
        @(negedge inter_clk);
        check("up_arm_up", 32'(bus.ctr_up), 32'd1);
        @(negedge inter_clk);
        ticks(1);
        check("timer_999", 32'(timer), 32'd999);
        ticks(999);
        check("timer_zero", 32'(timer), 32'd0);
        check("timer_zero_state", 32'(state), 32'd3);
        ticks(1);
        check("to_state", 32'(state), 32'd5);
        check("to_lose", 32'(lose), 32'd1);
        check("to_win", 32'(win), 32'd0);
        check("to_timer", 32'(timer), 32'd0);
        tap_run(HOLD, p0, p1, lat);
        check("lose_tap", 32'(p0), 32'd0);
        check("lose_digits", 32'(digits()), 32'h11);

        // Final count and timeout tick decided on the same cycle
        start_round(1'b0);
        repeat (2) @(negedge inter_clk);
        for (int t = 1; t <= 16; t++) tap_run(HOLD, p0, p1, lat);
        check("sim_digits", 32'(digits()), 32'h01);
        ticks(1000);
        check("sim_timer", 32'(timer), 32'd0);
        check("sim_run", 32'(state), 32'd3);
        tap = 1'b1;
        wait_count("sim_final_tap");
        tap = 1'b0;
        @(negedge inter_clk);
        check("sim_pre", 32'(state), 32'd3);
        tick = 1'b1;
        @(negedge inter_clk);
        tick = 1'b0;
        check("sim_state", 32'(state), 32'd4);
        check("sim_win", 32'(win), 32'd1);
        check("sim_lose", 32'(lose), 32'd0);
        check("sim_end_digits", 32'(digits()), 32'h00);

        // Start abort mid-round, then asynchronous reset mid-round
        start_round(1'b0);
        repeat (2) @(negedge inter_clk);
        ticks(500);
        check("abort_timer", 32'(timer), 32'd500);
        start_round(1'b0);
        check("abort_state", 32'(state), 32'd1);
        @(negedge inter_clk);
        check("abort_reload", 32'(timer), 32'(TIME_LIMIT));
        @(negedge inter_clk);
        ticks(500);
        check("mid_timer", 32'(timer), 32'd500);
        tap = 1'b1;
        wait_count("mid_tap");
        clr = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_timer", 32'(timer), 32'd0);
        check("mid_rst_cnt", 32'(bus.ctr_cnt), 32'd0);
        check("mid_rst_up", 32'(bus.ctr_up), 32'd1);
        check("mid_rst_win", 32'(win), 32'd0);
        check("mid_rst_lose", 32'(lose), 32'd0);
        tap = 1'b0;
        @(negedge inter_clk);
        clr = 1'b1;
        @(negedge inter_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
